mem_port_arbiter: RTL

- Shares one single-port, handshake-based memory between the fetch stage (instruction reads) and the MEM stage (data loads/stores driven by the EX/MEM mem_ctrl and result/src fields).
- Serialises accesses with data-over-instruction priority and holds read data.
- Drives one global stall that freezes PC, IF/ID, ID/EX and EX/MEM until every access requested this cycle has completed.
- Includes a timeout watchdog so an unresponsive memory cannot deadlock the core.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one handshake memory port between instruction fetch and the MEM stage.
// Data wins ties; a watchdog forces completion if the memory never acknowledges.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_done_o,
    input  logic                  dm_read_i,
    input  logic                  dm_write_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stall_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       dm_pend;
    logic       if_pend;
    logic       finish;

    // A requester that already completed stays quiet until the pipeline advances.
    assign dm_pend = (dm_read_i | dm_write_i) & ~dm_done_o;
    assign if_pend = if_req_i & ~if_done_o;
    assign stall_o = dm_pend | if_pend;
    assign finish  = mem_ack_i | (wait_cnt == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            dm_done_o   <= 1'b0;
            if_done_o   <= 1'b0;
            timeout_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            // Completion below overrides this clear; both cannot apply in one cycle anyway.
            if (!stall_o) begin
                dm_done_o <= 1'b0;
                if_done_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (dm_pend) begin
                        state       <= DATA;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_write_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (if_pend) begin
                        state      <= INSTR;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
                end
                DATA, INSTR: begin
                    if (finish) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        wait_cnt  <= '0;
                        if (!mem_ack_i) timeout_o <= 1'b1;
                        if (state == DATA) begin
                            dm_done_o <= 1'b1;
                            if (!mem_we_o) dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
